note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 12500000, clocks per duration unit.
REQ-002 SHALL have parameter GAP_CYCLES, default 500000, silent clocks between notes.
REQ-003 SHALL have port clock  input  1  single clock; all state on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin playback at entry 0.
REQ-006 SHALL have port stop  input  1  one-cycle request to abort playback.
REQ-007 SHALL have port loop  input  1  replay from entry 0 at end marker (see REQ-025).
REQ-008 SHALL have port wr_en  input  1  note-table write strobe.
REQ-009 SHALL have port wr_addr  input  4  note-table write index.
REQ-010 SHALL have port wr_hz  input  32  wave period count for entry; 0 means rest.
REQ-011 SHALL have port wr_len  input  4  note length in beats; 0 means end marker.
REQ-012 SHALL have port play_note  output  1  enables the triangle wave generator.
REQ-013 SHALL have port hz  output  32  period count driven to the generator.
REQ-014 SHALL have port duration  output  4  length field driven to the generator.
REQ-015 SHALL have port gen_reset  output  1  one-cycle active-high restart pulse for the generator.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port note_idx  output  4  current table index.
REQ-018 SHALL have port done  output  1  one-cycle pulse when playback ends without loop.

Function
REQ-019 SHALL hold a 16-entry table of {hz[31:0], len[3:0]}, written on wr_en only in IDLE; writes in other states are ignored.
REQ-020 SHALL implement FSM IDLE -> LOAD -> PLAY -> GAP -> LOAD ..., with END returning to IDLE.
REQ-021 IDLE: start moves to LOAD with note_idx=0; start in any other state is ignored.
REQ-022 LOAD (1 cycle): latch table[note_idx] into hz/duration, assert gen_reset; if len==0 go to END, else go to PLAY.
REQ-023 PLAY: load beat counter with len*BEAT_CYCLES-1, decrement each cycle; play_note=1 unless latched hz==0 (rest); on counter 0 go to GAP.
REQ-024 GAP: play_note=0 for exactly GAP_CYCLES cycles; then note_idx increments and FSM goes to LOAD; after index 15 the sequence treats the next entry as an end marker.
REQ-025 END (1 cycle): if looping is active, set note_idx=0 and go to LOAD; else pulse done and go to IDLE.
REQ-026 stop in any non-IDLE state SHALL force IDLE on the next edge, play_note=0 that cycle; done not pulsed.
REQ-027 start and stop in the same cycle: stop wins; FSM stays or returns to IDLE.
REQ-028 Beat counter SHALL be 32 bits; len*BEAT_CYCLES computed unsigned without truncation for len<=15.
REQ-029 hz/duration outputs SHALL change only in LOAD and remain stable through PLAY and GAP.
REQ-030 A table whose entry 0 has len==0 SHALL produce LOAD, END, done with no play_note.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, note_idx=0, hz=0, duration=0, play_note=0, gen_reset=0, busy=0, done=0, counters=0.
REQ-032 Table contents SHALL reset to all-zero (every entry an end marker).
REQ-033 reset_n assertion mid-note SHALL silence play_note without waiting for a clock edge.

Configuration
REQ-034 With NOTE_SEQUENCER_LOOP_EN defined, the loop input SHALL be honoured per REQ-025.
REQ-035 Without NOTE_SEQUENCER_LOOP_EN, the loop input SHALL be ignored and END always pulses done and returns to IDLE.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2)
REQ-036 Write entry0={1000,2}, entry1={0,0}; pulse start -> gen_reset 1 cycle, play_note high 8 cycles, low 2, then done pulse, busy low.
REQ-037 Entry0={0,1} rest, entry1={500,1}, entry2 end -> play_note low 4 cycles, gap 2, high 4 cycles with hz=500.
REQ-038 Three-note table, stop pulsed in 3rd PLAY cycle of note 1 -> next cycle IDLE, play_note=0, busy=0, no done.
REQ-039 LOOP_EN defined, loop=1, two-note table -> note_idx sequence 0,1,0,1,... with no done; drop loop -> done after the next end marker.
REQ-040 Assert reset_n low during PLAY -> play_note=0 asynchronously; after release, start plays nothing and pulses done (table cleared).
REQ-041 wr_en during busy to entry 0 -> after playback, readback via replay shows original value.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a 16-entry note table and drives a triangle
// wave generator. Each entry holds a period count and a length in beats.
// Length 0 marks the end of the sequence, and period 0 is a silent rest.
// Build option: define NOTE_SEQUENCER_LOOP_EN so that the loop input replays
// the table from entry 0 whenever the end marker is reached.
module note_sequencer #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_hz,
  input  logic [3:0]  wr_len,
  output logic        play_note,
  output logic [31:0] hz,
  output logic [3:0]  duration,
  output logic        gen_reset,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    END  = 3'd4
  } state_t;

  localparam logic [31:0] BEAT_C = 32'(BEAT_CYCLES);
  localparam logic [31:0] GAP_LD = 32'(GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] tbl_hz  [16];
  logic [3:0]  tbl_len [16];
  logic [31:0] hz_q;
  logic [3:0]  dur_q;
  logic [31:0] cnt;
  logic [3:0]  idx_q;
  logic        past_end;
  logic        loop_act;
  logic [31:0] ld_hz;
  logic [3:0]  ld_len;
  logic [31:0] beat_total;

`ifdef NOTE_SEQUENCER_LOOP_EN
  assign loop_act = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_act    = 1'b0;
`endif

  // After the last slot has played, the entry read in LOAD is forced to an
  // end marker so the index never wraps back to 0 on its own.
  assign ld_hz      = past_end ? 32'd0 : tbl_hz[idx_q];
  assign ld_len     = past_end ? 4'd0  : tbl_len[idx_q];
  assign beat_total = 32'(ld_len) * BEAT_C;

  assign hz       = hz_q;
  assign duration = dur_q;
  assign note_idx = idx_q;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_n   = state;
    gen_reset = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    play_note = 1'b0;
    case (state)
      IDLE: if (start && !stop) state_n = LOAD;
      LOAD: begin
        gen_reset = 1'b1;
        state_n   = (ld_len == 4'd0) ? END : PLAY;
      end
      PLAY: begin
        play_note = (hz_q != 32'd0);
        if (cnt == 32'd0) state_n = GAP;
      end
      GAP:  if (cnt == 32'd0) state_n = LOAD;
      END: begin
        if (loop_act) state_n = LOAD;
        else begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (stop && state != IDLE) begin
      state_n = IDLE;
      done    = 1'b0;
    end
  end

  // Note table: writable only while idle, cleared to end markers by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        tbl_hz[i]  <= 32'd0;
        tbl_len[i] <= 4'd0;
      end
    end else if (wr_en && state == IDLE) begin
      tbl_hz[wr_addr]  <= wr_hz;
      tbl_len[wr_addr] <= wr_len;
    end
  end

  // Generator parameters are latched only in LOAD and held through PLAY/GAP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hz_q  <= 32'd0;
      dur_q <= 4'd0;
    end else if (state == LOAD) begin
      hz_q  <= ld_hz;
      dur_q <= ld_len;
    end
  end

  // Shared down-counter: beats of the note in PLAY, silent cycles in GAP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                 cnt <= 32'd0;
    else if (state_n == IDLE)                     cnt <= 32'd0;
    else if (state == LOAD && state_n == PLAY)    cnt <= beat_total - 32'd1;
    else if (state == PLAY && state_n == GAP)     cnt <= GAP_LD;
    else if (cnt != 32'd0)                        cnt <= cnt - 32'd1;
  end

  // Table index: restarts at 0 on start or loop, advances after each gap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= 4'd0;
      past_end <= 1'b0;
    end else if (state_n == LOAD) begin
      if (state == IDLE || state == END) begin
        idx_q    <= 4'd0;
        past_end <= 1'b0;
      end else if (state == GAP) begin
        if (idx_q == 4'd15) past_end <= 1'b1;
        else                idx_q    <= idx_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2. A model of the
// note table expands into a per-cycle list of expected outputs after start.
module tb_note_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0, wr_len = 4'd0;
  logic [31:0] wr_hz = 32'd0;
  logic        play_note, gen_reset, busy, done;
  logic [31:0] hz;
  logic [3:0]  duration, note_idx;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        play;
    logic        gr;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
    logic        hzchk;
    logic [31:0] hz;
    logic [3:0]  dur;
    logic        lp;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] m_hz [16];
  logic [3:0]  m_len[16];

  note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_hz(wr_hz), .wr_len(wr_len),
    .play_note(play_note), .hz(hz), .duration(duration), .gen_reset(gen_reset),
    .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_hz[i]  = 32'd0;
      m_len[i] = 4'd0;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] h, input logic [3:0] l);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 4'(a); wr_hz = h; wr_len = l;
    @(negedge clock);
    wr_en = 1'b0;
    m_hz[a]  = h;
    m_len[a] = l;
  endtask

  // Expand the table into expected cycles: one load per entry, len*BEAT
  // playing cycles, GAP silent cycles; an end marker (or running off the
  // last slot) produces a one-cycle end that either loops or signals done.
  task automatic build(input int passes);
    int i, p;
    logic [3:0]  len;
    logic [31:0] h;
    logic        la, lp;
    ev_t         e;
    exp_q.delete();
    i = 0; p = 0;
    while (1) begin
      lp = (p < passes);
      if (i > 15) begin len = 4'd0; h = 32'd0; end
      else begin len = m_len[i]; h = m_hz[i]; end
      e = '0;
      e.gr = 1'b1; e.busy = 1'b1; e.lp = lp;
      e.idx = (i > 15) ? 4'd15 : 4'(i);
      exp_q.push_back(e);
      if (len == 4'd0) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
        la = lp;
`else
        la = 1'b0;
`endif
        e.gr = 1'b0; e.done = !la;
        exp_q.push_back(e);
        if (la) begin p++; i = 0; end
        else break;
      end else begin
        e.gr = 1'b0; e.hzchk = 1'b1; e.hz = h; e.dur = len; e.play = (h != 32'd0);
        repeat (int'(len) * BEAT) exp_q.push_back(e);
        e.play = 1'b0;
        repeat (GAP) exp_q.push_back(e);
        i++;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".play"}, 32'(play_note), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".gr"}, 32'(gen_reset), 32'd0);
  endtask

  // Pulse start, then compare every cycle of the expected list. stop_k and
  // wr_k (cycle offsets, -1 for none) inject a stop or a busy-time write.
  task automatic run(input string name, input int stop_k, input int wr_k);
    ev_t e;
    @(negedge clock);
    start = 1'b1; loop = exp_q[0].lp;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      loop = e.lp;
      if (k == wr_k) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_hz = 32'hDEAD; wr_len = 4'd7;
      end
      if (k == stop_k) stop = 1'b1;
      #1;
      chk($sformatf("%s.play@%0d", name, k), 32'(play_note), 32'(e.play));
      chk($sformatf("%s.gr@%0d", name, k), 32'(gen_reset), 32'(e.gr));
      chk($sformatf("%s.busy@%0d", name, k), 32'(busy), 32'(e.busy));
      chk($sformatf("%s.done@%0d", name, k), 32'(done), 32'(e.done));
      chk($sformatf("%s.idx@%0d", name, k), 32'(note_idx), 32'(e.idx));
      if (e.hzchk) begin
        chk($sformatf("%s.hz@%0d", name, k), hz, e.hz);
        chk($sformatf("%s.dur@%0d", name, k), 32'(duration), 32'(e.dur));
      end
      @(negedge clock);
      stop = 1'b0; wr_en = 1'b0;
      if (k == stop_k) break;
    end
    #1;
    check_idle({name, ".after"});
  endtask

  initial begin
    int stop_k, np;
    clear_model();

    // Reset state
    #3;
    check_idle("reset");
    chk("reset.hz", hz, 32'd0);
    chk("reset.dur", 32'(duration), 32'd0);
    chk("reset.idx", 32'(note_idx), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Empty table after reset: load, end, done, no sound
    build(0);
    run("empty", -1, -1);

    // Single note of two beats
    wr(0, 32'd1000, 4'd2);
    wr(1, 32'd0, 4'd0);
    build(0);
    run("one", -1, -1);

    // Rest followed by a note
    wr(0, 32'd0, 4'd1);
    wr(1, 32'd500, 4'd1);
    wr(2, 32'd0, 4'd0);
    build(0);
    run("rest", -1, -1);

    // start and stop together while idle: stays idle
    @(negedge clock);
    start = 1'b1; stop = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    #1;
    check_idle("startstop");

    // Stop in the third playing cycle of note 1
    wr(0, 32'd111, 4'd1);
    wr(1, 32'd222, 4'd2);
    wr(2, 32'd333, 4'd1);
    wr(3, 32'd0, 4'd0);
    build(0);
    stop_k = -1; np = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (stop_k < 0 && exp_q[k].idx == 4'd1 && exp_q[k].play) begin
        np++;
        if (np == 3) stop_k = k;
      end
    end
    run("stop", stop_k, -1);

    // Write during playback is ignored; replay shows original entry 0
    wr(0, 32'd777, 4'd1);
    wr(1, 32'd888, 4'd1);
    wr(2, 32'd0, 4'd0);
    build(0);
    run("busywr", -1, 3);
    run("replay", -1, -1);

    // Every slot holds a note: sequence ends after slot 15
    for (int i = 0; i < 16; i++) wr(i, 32'(i + 1), 4'd1);
    build(0);
    run("full", -1, -1);

    // Loop held for two passes, then dropped (ignored unless loop is built in)
    wr(0, 32'd1234, 4'd1);
    wr(1, 32'd4321, 4'd1);
    wr(2, 32'd0, 4'd0);
    build(2);
    run("loop", -1, -1);

    // Randomized tables
    for (int t = 0; t < 5; t++) begin
      int endp;
      endp = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        if (i == endp) wr(i, $urandom, 4'd0);
        else wr(i, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 4'($urandom_range(1, 2)));
      end
      build(int'($urandom_range(0, 1)));
      run($sformatf("rand%0d", t), -1, -1);
    end

    // Asynchronous reset while a note plays
    wr(0, 32'd1000, 4'd2);
    wr(1, 32'd0, 4'd0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("arst.pre_play", 32'(play_note), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst.play", 32'(play_note), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.hz", hz, 32'd0);
    chk("arst.idx", 32'(note_idx), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clear_model();
    build(0);
    run("cleared", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
